// File: rtl/wb_regbank_pkg.sv
// Shared constants and types for the write-back register bank and its staging register.
package wb_regbank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register numbers shared with the destination-register select encoding.
  localparam int LINK_REG = 31;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } stage_state_e;

endpackage

// File: rtl/wb_regbank_if.sv
// Write-back request and read-port bundle between the datapath and the register bank.
interface wb_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              commit_en;
  logic              flush;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              pend_valid;

  modport master (
    output wb_valid, wb_addr, wb_data, commit_en, flush, rs_addr, rt_addr,
    input  wb_ready, rs_data, rt_data, pend_valid
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, commit_en, flush, rs_addr, rt_addr,
    output wb_ready, rs_data, rt_data, pend_valid
  );
endinterface

// File: rtl/wb_stage_reg.sv
// One-entry valid/ready staging register between write acceptance and array commit.
module wb_stage_reg
  import wb_regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              commit_en,
  input  logic              flush,
  output logic              wb_ready,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] stage_addr,
  output logic [DATA_W-1:0] stage_data,
  output logic              commit_fire
);

  stage_state_e state, state_nxt;
  logic         xfer;

  always_comb begin
    state_nxt   = state;
    wb_ready    = 1'b0;
    xfer        = 1'b0;
    commit_fire = 1'b0;

    wb_ready    = !flush && ((state == ST_EMPTY) || commit_en);
    xfer        = wb_valid && wb_ready;
    // Flush kills both the drain and the capture on the same edge.
    commit_fire = (state == ST_PENDING) && commit_en && !flush;

    if (flush)            state_nxt = ST_EMPTY;
    else if (xfer)        state_nxt = ST_PENDING;
    else if (commit_fire) state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      stage_addr <= '0;
      stage_data <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        stage_addr <= wb_addr;
        stage_data <= wb_data;
      end
    end
  end

  assign pend_valid = (state == ST_PENDING);

endmodule

// File: rtl/wb_regbank.sv
// General register array with a staged write port and two bypassed combinational read ports.
module wb_regbank
  import wb_regbank_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NREGS       = 32,
  parameter int ZERO_REG_EN = 0
) (
  input  logic         clk,
  input  logic         rst,
  wb_regbank_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREGS];

  logic              ready_s;
  logic              pend_s;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic              commit_fire;
  logic              zero_hit;

  wb_stage_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (bus.wb_valid),
    .wb_addr    (bus.wb_addr),
    .wb_data    (bus.wb_data),
    .commit_en  (bus.commit_en),
    .flush      (bus.flush),
    .wb_ready   (ready_s),
    .pend_valid (pend_s),
    .stage_addr (stage_addr),
    .stage_data (stage_data),
    .commit_fire(commit_fire)
  );

  // Writes to the hardwired zero register still drain, they just never land.
  assign zero_hit = (ZERO_REG_EN != 0) && (stage_addr == ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit_fire && !zero_hit) begin
      regs[stage_addr] <= stage_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
    if ((ZERO_REG_EN != 0) && (addr == ADDR_W'(ZERO_REG)))
      return '0;
    else if (pend_s && (addr == stage_addr))
      return stage_data;
    else
      return regs[addr];
  endfunction

  always_comb begin
    bus.rs_data = rd_port(bus.rs_addr);
    bus.rt_data = rd_port(bus.rt_addr);
  end

  assign bus.wb_ready   = ready_s;
  assign bus.pend_valid = pend_s;

endmodule

// File: tb/tb_wb_regbank.sv
// Directed bench for wb_regbank: one instance with a writable r0, one with r0 hardwired to zero.
module tb_wb_regbank;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_regbank_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  wb_regbank_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

  wb_regbank #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .ZERO_REG_EN(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  wb_regbank #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .ZERO_REG_EN(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus0.wb_valid = 0; bus0.wb_addr = 0; bus0.wb_data = 0;
    bus0.commit_en = 0; bus0.flush = 0; bus0.rs_addr = 0; bus0.rt_addr = 0;
    bus1.wb_valid = 0; bus1.wb_addr = 0; bus1.wb_data = 0;
    bus1.commit_en = 0; bus1.flush = 0; bus1.rs_addr = 0; bus1.rt_addr = 0;

    // Reset
    tick();
    rst = 1'b0;
    bus0.rs_addr = 5; bus0.rt_addr = 31;
    #1;
    chk("rst_rs5", bus0.rs_data, 32'h0);
    chk("rst_rt31", bus0.rt_data, 32'h0);
    chk("rst_ready", 32'(bus0.wb_ready), 32'd1);
    chk("rst_pend", 32'(bus0.pend_valid), 32'd0);

    // Basic write, bypass, commit
    bus0.wb_valid = 1; bus0.wb_addr = 7; bus0.wb_data = 32'hDEADBEEF; bus0.rs_addr = 7;
    #1;
    chk("no_same_cycle_fwd", bus0.rs_data, 32'h0);
    tick();
    bus0.wb_valid = 0;
    #1;
    chk("wr7_pend", 32'(bus0.pend_valid), 32'd1);
    chk("wr7_ready", 32'(bus0.wb_ready), 32'd0);
    chk("wr7_bypass", bus0.rs_data, 32'hDEADBEEF);
    tick();
    chk("wr7_hold_pend", 32'(bus0.pend_valid), 32'd1);
    bus0.commit_en = 1;
    #1;
    chk("wr7_ready_commit", 32'(bus0.wb_ready), 32'd1);
    tick();
    bus0.commit_en = 0;
    #1;
    chk("wr7_drained", 32'(bus0.pend_valid), 32'd0);
    chk("wr7_array", bus0.rs_data, 32'hDEADBEEF);

    // Back-to-back same address
    bus0.commit_en = 1; bus0.rt_addr = 3;
    bus0.wb_valid = 1; bus0.wb_addr = 3; bus0.wb_data = 32'h11;
    #1;
    chk("b2b_ready0", 32'(bus0.wb_ready), 32'd1);
    tick();
    bus0.wb_data = 32'h22;
    #1;
    chk("b2b_ready1", 32'(bus0.wb_ready), 32'd1);
    chk("b2b_rt_11", bus0.rt_data, 32'h11);
    tick();
    bus0.wb_valid = 0;
    #1;
    chk("b2b_rt_22", bus0.rt_data, 32'h22);
    chk("b2b_pend", 32'(bus0.pend_valid), 32'd1);
    tick();
    chk("b2b_drained", 32'(bus0.pend_valid), 32'd0);
    chk("b2b_array", bus0.rt_data, 32'h22);
    bus0.commit_en = 0;

    // Flush beats commit and capture
    bus0.wb_valid = 1; bus0.wb_addr = 31; bus0.wb_data = 32'hCAFE;
    tick();
    bus0.flush = 1; bus0.commit_en = 1;
    bus0.wb_addr = 4; bus0.wb_data = 32'h1;
    #1;
    chk("flush_ready", 32'(bus0.wb_ready), 32'd0);
    tick();
    bus0.flush = 0; bus0.commit_en = 0; bus0.wb_valid = 0;
    bus0.rs_addr = 31; bus0.rt_addr = 4;
    #1;
    chk("flush_pend", 32'(bus0.pend_valid), 32'd0);
    chk("flush_r31", bus0.rs_data, 32'h0);
    chk("flush_r4", bus0.rt_data, 32'h0);

    // Reset while a write is staged
    bus0.wb_valid = 1; bus0.wb_addr = 9; bus0.wb_data = 32'hAB; bus0.rs_addr = 9;
    tick();
    bus0.wb_valid = 0;
    #1;
    chk("mid_bypass9", bus0.rs_data, 32'hAB);
    rst = 1; bus0.commit_en = 1;
    tick();
    rst = 0; bus0.commit_en = 0; bus0.rt_addr = 7;
    #1;
    chk("mid_pend", 32'(bus0.pend_valid), 32'd0);
    chk("mid_r9", bus0.rs_data, 32'h0);
    chk("mid_r7_cleared", bus0.rt_data, 32'h0);

    // Register 0: writable on dut0, hardwired zero on dut1
    bus0.wb_valid = 1; bus0.wb_addr = 0; bus0.wb_data = 32'hFFFF; bus0.commit_en = 1; bus0.rs_addr = 0;
    bus1.wb_valid = 1; bus1.wb_addr = 0; bus1.wb_data = 32'hFFFF; bus1.commit_en = 1; bus1.rs_addr = 0;
    #1;
    chk("z_rs0_c0", bus1.rs_data, 32'h0);
    tick();
    bus0.wb_valid = 0; bus1.wb_valid = 0;
    #1;
    chk("z_pend", 32'(bus1.pend_valid), 32'd1);
    chk("z_rs0_c1", bus1.rs_data, 32'h0);
    chk("nz_bypass0", bus0.rs_data, 32'hFFFF);
    tick();
    chk("z_drained", 32'(bus1.pend_valid), 32'd0);
    chk("z_rs0_c2", bus1.rs_data, 32'h0);
    chk("nz_array0", bus0.rs_data, 32'hFFFF);
    bus0.commit_en = 0; bus1.commit_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
